// File: rtl/noc_pkg.sv
// Shared NoC flit definitions used by the master NA request path and the router.
package noc_pkg;
    localparam int FLIT_W   = 37;
    localparam int NUM_VC   = 8;
    localparam int VC_ID_W  = 3;
    localparam int HEAD_BIT = 36;
    localparam int TAIL_BIT = 35;
    localparam int VC_MSB   = 34;
    localparam int VC_LSB   = 32;

    typedef struct packed {
        logic               head;
        logic               tail;
        logic [VC_ID_W-1:0] vc;
        logic [31:0]        payload;
    } flit_t;
endpackage

// File: rtl/noc_vc_input_buffer_if.sv
// Upstream flit link plus switch-side valid/ready link of the VC input buffer.
interface noc_vc_input_buffer_if;
    import noc_pkg::*;

    logic [FLIT_W-1:0]  noc_data;
    logic               is_valid;
    logic [NUM_VC-1:0]  is_on_off;
    logic [NUM_VC-1:0]  is_allocatable;
    logic [FLIT_W-1:0]  out_data;
    logic [VC_ID_W-1:0] out_vc;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  noc_data, is_valid, out_ready,
        output is_on_off, is_allocatable, out_data, out_vc, out_valid
    );

    modport master (
        output noc_data, is_valid, out_ready,
        input  is_on_off, is_allocatable, out_data, out_vc, out_valid
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter; the grant is frozen while a request waits unaccepted.
module noc_rr_arbiter #(
    parameter int N = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 accept,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr, lock_idx, search_idx;
    logic             locked, found;
    int               c;

    always_comb begin
        search_idx = '0;
        found      = 1'b0;
        c          = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found      = 1'b1;
                search_idx = IDX_W'(c);
            end
        end
    end

    assign grant_valid = |req;
    assign grant_idx   = locked ? lock_idx : search_idx;
    assign grant       = grant_valid ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (grant_valid && accept) begin
            ptr    <= IDX_W'((int'(grant_idx) + 1) % N);
            locked <= 1'b0;
        end else if (grant_valid) begin
            locked   <= 1'b1;
            lock_idx <= grant_idx;
        end else begin
            locked <= 1'b0;
        end
    end
endmodule

// File: rtl/noc_vc_input_buffer.sv
// Router input stage: per-VC flit FIFOs, on/off + allocatable flow control, RR switch output.
// Defining NOC_VCBUF_ERR_EN adds the sticky err_flags[2:0] output.
//
// Per-VC packet FSM:
//   state   | meaning
//   ST_FREE | no packet in progress; upstream may start a new packet
//   ST_BUSY | head stored, tail not yet popped
module noc_vc_input_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int OFF_THRESH = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    noc_vc_input_buffer_if.slave bus
`ifdef NOC_VCBUF_ERR_EN
    ,
    output logic [2:0]           err_flags
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] ST_FREE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    flit_t              in_flit;
    logic [VC_ID_W-1:0] wr_vc;
    logic [NUM_VC-1:0]  full, not_empty, wr_en, rd_en, vc_grant, on_off, busy;
    flit_t              head_flit [NUM_VC];
    logic [VC_ID_W-1:0] gnt_idx;
    logic               gnt_valid, pop;

    assign in_flit = flit_t'(bus.noc_data);
    assign wr_vc   = in_flit.vc;
    assign pop     = gnt_valid & bus.out_ready;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        flit_t            mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr, rd_ptr;
        logic [CNT_W-1:0] count, next_count;
        logic [0:0]       state;
        logic             on_off_q;

        // fullness uses the pre-read count, so a full VC drops even when popped this cycle
        assign full[v]      = (count == CNT_W'(DEPTH));
        assign not_empty[v] = (count != '0);
        assign wr_en[v]     = bus.is_valid && (wr_vc == VC_ID_W'(v)) && !full[v];
        assign rd_en[v]     = pop && vc_grant[v];
        assign head_flit[v] = mem[rd_ptr];
        assign on_off[v]    = on_off_q;
        assign busy[v]      = (state == ST_BUSY);

        always_comb begin
            next_count = count;
            if (wr_en[v] && !rd_en[v])
                next_count = count + 1'b1;
            else if (!wr_en[v] && rd_en[v])
                next_count = count - 1'b1;
        end

        always_ff @(posedge clock) begin
            if (wr_en[v])
                mem[wr_ptr] <= in_flit;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                on_off_q <= 1'b1;
            end else begin
                count    <= next_count;
                on_off_q <= (DEPTH - int'(next_count)) > OFF_THRESH;
                if (wr_en[v])
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_en[v])
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end

        // a head written in the same cycle as a tail pop keeps the VC busy
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
                state <= ST_FREE;
            else if (wr_en[v] && in_flit.head)
                state <= ST_BUSY;
            else if (rd_en[v] && mem[rd_ptr].tail)
                state <= ST_FREE;
        end
    end

    noc_rr_arbiter #(.N(NUM_VC)) u_arb (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (not_empty),
        .accept      (bus.out_ready),
        .grant       (vc_grant),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    assign bus.out_valid      = gnt_valid;
    assign bus.out_vc         = gnt_idx;
    assign bus.out_data       = gnt_valid ? head_flit[gnt_idx] : '0;
    assign bus.is_on_off      = on_off;
    assign bus.is_allocatable = ~busy;

`ifdef NOC_VCBUF_ERR_EN
    logic [2:0] err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (bus.is_valid) begin
            if (full[wr_vc])
                err_q[0] <= 1'b1;
            if (in_flit.head && busy[wr_vc])
                err_q[1] <= 1'b1;
            if (!in_flit.head && !busy[wr_vc])
                err_q[2] <= 1'b1;
        end
    end

    assign err_flags = err_q;
`endif
endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Scoreboard bench for noc_vc_input_buffer: per-VC expected queues plus a spec-level RR model.
module tb_noc_vc_input_buffer;
    import noc_pkg::*;

    localparam int DEPTH      = 4;
    localparam int OFF_THRESH = 1;

    typedef struct {
        logic [FLIT_W-1:0] flit;
        int                stamp;
    } ent_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    noc_vc_input_buffer_if bus();
`ifdef NOC_VCBUF_ERR_EN
    logic [2:0] err_flags;
`endif

    noc_vc_input_buffer #(.DEPTH(DEPTH), .OFF_THRESH(OFF_THRESH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef NOC_VCBUF_ERR_EN
        ,
        .err_flags (err_flags)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    // reference state: flits in each VC, packet state, RR pointer and held grant
    ent_t              q [NUM_VC][$];
    logic [NUM_VC-1:0] alloc_m = '1;
    logic [2:0]        err_m = '0;
    logic [2:0]        err_next = '0;
    int                m_ptr = 0;
    bit                m_hold = 0;
    int                m_hold_vc = 0;

    always @(posedge clock) edge_cnt++;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // flits visible in the DUT now; the newest entry may land only at the next edge
    function automatic int vis(int v);
        int s;
        s = q[v].size();
        if (s > 0 && q[v][s-1].stamp > edge_cnt) s--;
        return s;
    endfunction

    function automatic int total_model();
        int t;
        t = 0;
        for (int v = 0; v < NUM_VC; v++) t += q[v].size();
        return t;
    endfunction

    function automatic logic [FLIT_W-1:0] mk(bit h, bit t, int vc, logic [31:0] p);
        return {h, t, VC_ID_W'(vc), p};
    endfunction

    always @(negedge clock) begin : monitor
        int ev, tail_pop, head_vc, c;
        logic [NUM_VC-1:0] exp_onoff;
        bit any;
        if (reset_n) begin
            any = 0;
            ev = 0;
            tail_pop = -1;
            head_vc = -1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (vis(v) > 0) any = 1;
                exp_onoff[v] = (DEPTH - vis(v)) > OFF_THRESH;
            end
            check("out_valid", bus.out_valid, any);
            check("is_on_off", bus.is_on_off, exp_onoff);
            check("is_allocatable", bus.is_allocatable, alloc_m);
`ifdef NOC_VCBUF_ERR_EN
            check("err_flags", err_flags, err_m);
`endif
            if (any) begin
                if (m_hold) begin
                    ev = m_hold_vc;
                end else begin
                    for (int i = NUM_VC - 1; i >= 0; i--) begin
                        c = (m_ptr + i) % NUM_VC;
                        if (vis(c) > 0) ev = c;
                    end
                end
                check("out_vc", bus.out_vc, ev);
                check("out_data", bus.out_data, q[ev][0].flit);
                if (bus.out_ready) begin
                    if (q[ev][0].flit[TAIL_BIT]) tail_pop = ev;
                    void'(q[ev].pop_front());
                    m_ptr  = (ev + 1) % NUM_VC;
                    m_hold = 0;
                end else begin
                    m_hold    = 1;
                    m_hold_vc = ev;
                end
            end else begin
                m_hold = 0;
            end
            for (int v = 0; v < NUM_VC; v++)
                if (q[v].size() > 0 && q[v][q[v].size()-1].stamp == edge_cnt + 1
                    && q[v][q[v].size()-1].flit[HEAD_BIT])
                    head_vc = v;
            if (tail_pop >= 0) alloc_m[tail_pop] = 1'b1;
            if (head_vc >= 0) alloc_m[head_vc] = 1'b0;
            err_m = err_m | err_next;
            err_next = '0;
        end
    end

    task automatic cycle(bit vld, logic [FLIT_W-1:0] f, bit rdy);
        int v;
        @(posedge clock);
        #1;
        bus.is_valid  = vld;
        bus.noc_data  = vld ? f : '0;
        bus.out_ready = rdy;
        if (vld) begin
            v = int'(f[VC_MSB:VC_LSB]);
            if (f[HEAD_BIT] && !alloc_m[v]) err_next[1] = 1'b1;
            if (!f[HEAD_BIT] && alloc_m[v]) err_next[2] = 1'b1;
            if (q[v].size() >= DEPTH) err_next[0] = 1'b1;
            else q[v].push_back('{flit: f, stamp: edge_cnt + 1});
        end
    endtask

    task automatic drain(int budget);
        int k;
        k = 0;
        while (total_model() != 0 && k < budget) begin
            cycle(0, '0, 1);
            k++;
        end
        check("drain_empty", total_model(), 0);
        cycle(0, '0, 0);
    endtask

    task automatic reset_checks();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_vc", bus.out_vc, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_is_on_off", bus.is_on_off, 8'hFF);
        check("rst_is_allocatable", bus.is_allocatable, 8'hFF);
`ifdef NOC_VCBUF_ERR_EN
        check("rst_err_flags", err_flags, 0);
`endif
    endtask

    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        bus.is_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.noc_data  = '0;
        for (int v = 0; v < NUM_VC; v++) q[v].delete();
        alloc_m = '1;
        err_m = '0;
        err_next = '0;
        m_ptr = 0;
        m_hold = 0;
        #1;
        reset_checks();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        bit vld, rdy;
        bus.is_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.noc_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_checks();
        #1;
        reset_n = 1'b1;
        repeat (2) cycle(0, '0, 0);

        // packet on VC1 held while out_ready is low
        cycle(1, mk(1, 0, 1, 32'h3100_0000), 0);
        cycle(1, mk(0, 0, 1, 32'h1), 0);
        cycle(1, mk(0, 1, 1, 32'h0), 0);
        cycle(0, '0, 0);
        check("vc1_alloc", bus.is_allocatable, 8'hFD);
        check("vc1_on_off", bus.is_on_off[1], 0);
        check("vc1_out_vc", bus.out_vc, 1);
        check("vc1_out_data", bus.out_data, {1'b1, 1'b0, 3'd1, 32'h3100_0000});
        repeat (3) cycle(0, '0, 1);
        cycle(0, '0, 0);
        check("vc1_release_alloc", bus.is_allocatable, 8'hFF);
        check("vc1_release_on_off", bus.is_on_off[1], 1);
        check("vc1_release_valid", bus.out_valid, 0);

        // overflow on VC0: fifth flit dropped
        for (int i = 0; i < 5; i++) cycle(1, mk(i == 0, i == 4, 0, 32'hA000 + i), 0);
        cycle(0, '0, 0);
        check("ovf_on_off", bus.is_on_off[0], 0);
`ifdef NOC_VCBUF_ERR_EN
        check("ovf_err0", err_flags[0], 1);
`endif
        drain(20);

        // fairness across VC0, VC3, VC7
        cycle(1, mk(1, 1, 0, 32'h0), 0);
        cycle(1, mk(1, 1, 3, 32'h3), 0);
        cycle(1, mk(1, 1, 7, 32'h7), 0);
        cycle(0, '0, 0);
        check("fair_first_vc", bus.out_vc, 0);
        drain(20);
        check("fair_alloc", bus.is_allocatable[7:1], 7'h7F);

        // simultaneous write and pop on VC2
        cycle(1, mk(1, 0, 2, 32'h21), 0);
        cycle(1, mk(0, 0, 2, 32'h22), 0);
        cycle(1, mk(0, 1, 2, 32'h23), 1);
        cycle(0, '0, 0);
        check("simul_on_off", bus.is_on_off[2], 1);
        check("simul_valid", bus.out_valid, 1);
        check("simul_out_data", bus.out_data, {1'b0, 1'b0, 3'd2, 32'h22});
        drain(20);

        // randomized traffic with a reset in the middle
        for (int n = 0; n < 3000; n++) begin
            vld = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 65);
            cycle(vld, mk($urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, NUM_VC - 1), $urandom), rdy);
            if (n == 1500) mid_reset();
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_vc_input_buffer.md
Name: noc_vc_input_buffer

Overview:
- Router-side input stage directly downstream of the master NA request path.
- Accepts 37-bit flits on noc_data/is_valid and stores them in per-virtual-channel FIFOs.
- Returns per-VC flow-control status upstream on is_on_off and is_allocatable.
- Presents buffered flits to the router switch through a round-robin valid/ready output.

Parameters:
- FLIT_W, 37, flit width. Fixed format: [36] head, [35] tail, [34:32] VC id, [31:0] payload/route. Head and tail both set means a single-flit packet.
- NUM_VC, 8, number of virtual channels. Equals the width of is_on_off and is_allocatable.
- VC_ID_W, 3, width of the VC id field; clog2(NUM_VC).
- DEPTH, 4, flits per VC FIFO. Power of two, at least 2.
- OFF_THRESH, 1, is_on_off[v] drops to 0 when free slots in VC v are at or below this value.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- noc_data  in  37  incoming flit.
- is_valid  in  1  noc_data is valid this cycle. No ready signal; upstream obeys is_on_off.
- is_on_off  out  8  per-VC on/off flow control; 1 = upstream may send.
- is_allocatable  out  8  per-VC "no packet in progress"; 1 = upstream may start a new packet on that VC.
- out_data  out  37  flit at the head of the granted VC FIFO.
- out_vc  out  3  VC of out_data.
- out_valid  out  1  at least one VC FIFO is non-empty.
- out_ready  in  1  switch consumes out_data this cycle when out_valid is also 1.

Behaviour:
- Reset values: all FIFOs empty; is_on_off = 8'hFF; is_allocatable = 8'hFF; out_valid = 0; out_vc = 0; out_data = 0; round-robin pointer = 0.
- Write: when is_valid=1, the flit goes to FIFO noc_data[34:32].
  - Fullness is judged on the registered count before this cycle's read.
  - A flit arriving at a full VC is dropped, even if the same VC is read in the same cycle.
- Read: when out_valid & out_ready, pop the granted VC.
  - Simultaneous write and read on the same non-full VC leaves the count unchanged.
- Latency: a flit written at edge N can appear on out_data after edge N; minimum one cycle through the block.
- Arbitration:
  - The grant is combinational over non-empty VCs, searching round-robin from the pointer.
  - After a pop, the pointer moves to the served VC + 1, wrapping 7 -> 0.
  - Without a pop, the grant stays put (out_data/out_vc stable while out_valid & !out_ready).
- is_on_off[v]: registered. Equals (DEPTH - next_count[v]) > OFF_THRESH, updated on the same edge as the count.
- is_allocatable[v]: registered, per-VC two-state FSM.
  - FREE -> BUSY on the edge where a head flit is written into v.
  - BUSY -> FREE on the edge where a tail flit is popped from v.
  - A single-flit packet (head & tail) written and later popped gives FREE -> BUSY -> FREE.
  - Head written and tail popped on the same VC in the same cycle: the head wins; the VC stays or becomes BUSY.
- Out-of-range cases: a body/tail flit to a FREE VC, or a head flit to a BUSY VC, is still stored; the FSM applies the rules above.
- Reset mid-packet: all state returns to reset values immediately (asynchronous); buffered flits are lost.

Optional Feature:
- Macro: NOC_VCBUF_ERR_EN.
- Defined: adds output err_flags[2:0], sticky until reset.
  - [0] overflow: write to a full VC.
  - [1] head flit to a BUSY VC.
  - [2] body/tail flit to a FREE VC.
  - Behaviour on the data path is unchanged.
- Undefined: port absent; these conditions are silently handled as in Behaviour.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W, NUM_VC, VC_ID_W.
  - Field index constants HEAD_BIT = 36, TAIL_BIT = 35, VC_MSB = 34, VC_LSB = 32.
  - Flit struct typedef, reused by MNA_request and the router.
- One sub-module: noc_rr_arbiter (NUM_VC request vector, pointer update on accept, one-hot grant plus encoded index).
- The FIFOs are inline generate loops.

Test Plan:
- Reset, then idle: is_on_off = 8'hFF, is_allocatable = 8'hFF, out_valid = 0.
- Packet on VC1 with out_ready=0:
  - Flits: head {1,0,3'd1,32'h3100_0000}, body {0,0,3'd1,32'h1}, tail {0,1,3'd1,32'h0}.
  - Response: is_allocatable = 8'hFD after the head edge; out_vc = 1; out_data = head; count 3 so is_on_off[1] = 0 with DEPTH=4, OFF_THRESH=1.
- Release of that packet:
  - Stimulus: raise out_ready for 3 cycles.
  - Response: out_data sequence head, body, tail; is_allocatable returns to 8'hFF on the edge after the tail pop; is_on_off[1] = 1.
- Overflow: write 5 flits to VC0 with out_ready=0 -> 5th flit dropped; 4 flits read back in order; err_flags[0]=1 when NOC_VCBUF_ERR_EN is defined.
- Fairness: single-flit packets preloaded in VC0, VC3 and VC7 with out_ready=1 -> out_vc sequence 0, 3, 7; is_allocatable restored per VC on each pop.
- Simultaneous events: out_ready=1 with VC2 holding 2 flits while a 3rd flit is written to VC2 -> count remains 2; is_on_off[2] stays 1; assert reset_n low mid-stream -> outputs at reset values within the same cycle.
